snes_pad_reader: RTL and testbench



---
 rtl/snes_pad_reader.sv | 197 +++++++++++++++++++
 tb/tb_snes_pad_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls an SNES game pad over latch/clock/data and presents an
// active-high 12-bit button word once per frame. A single clock domain with an
// internal tick enable replaces a separate protocol-rate divider.
// Optional build macro: SNES_PRESENCE_CHECK_EN -- when defined, a frame whose
// trailing four bits are not all high is treated as "pad absent".
module snes_pad_reader #(
    parameter int HALF_PERIOD = 300,   // clk cycles per protocol tick, >= 4
    parameter int POLL_TICKS  = 2778   // ticks from frame start to frame start, >= 36
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_data,
    output logic        snes_clk,
    output logic        data_latch,
    output logic [11:0] button_data,
    output logic        data_valid,
    output logic        ctrl_missing
);

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int FW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(POLL_TICKS - 1);

    typedef enum logic [2:0] {
        ST_START,
        ST_LATCH,
        ST_GAP,
        ST_LOW,
        ST_HIGH,
        ST_DONE,
        ST_IDLE
    } state_t;

    state_t         state_reg, state_next;
    logic [TW-1:0]  tick_cnt_reg;
    logic [FW-1:0]  frame_cnt_reg;
    logic [3:0]     bit_cnt_reg, bit_cnt_next;
    logic           latch_half_reg, latch_half_next;
    logic           sync1_reg, sync2_reg;
    logic [15:0]    raw_reg;
    logic           snes_clk_reg, data_latch_reg, data_valid_reg;
    logic [11:0]    button_data_reg;
    logic [11:0]    pressed;
    logic           tick;
    logic           enter_low;

    assign tick      = (tick_cnt_reg == TICK_LAST);
    assign enter_low = (state_next == ST_LOW) && (state_reg != ST_LOW);

    // The pad reports buttons active-low; flip each bit into the active-high word.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_invert
            assign pressed[gi] = ~raw_reg[gi];
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous pad data pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= serial_data;
            sync2_reg <= sync1_reg;
        end
    end

    // Next-state logic for the poll sequence.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        latch_half_next = latch_half_reg;
        case (state_reg)
            ST_START: begin
                state_next      = ST_LATCH;
                latch_half_next = 1'b0;
            end
            ST_LATCH: begin
                if (tick) begin
                    if (latch_half_reg) state_next = ST_GAP;
                    else                latch_half_next = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_next   = ST_LOW;
                    bit_cnt_next = 4'd0;
                end
            end
            ST_LOW: begin
                if (tick) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (tick) begin
                    if (bit_cnt_reg == 4'd15) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next   = ST_LOW;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (tick && (frame_cnt_reg == FRAME_LAST)) begin
                    state_next      = ST_LATCH;
                    latch_half_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    // State, tick and frame counters. Leaving DONE does not restart the tick
    // counter: DONE is a one-clk pass-through, and keeping the phase running
    // across it makes the frame period land on exactly POLL_TICKS*HALF_PERIOD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_START;
            bit_cnt_reg    <= 4'd0;
            latch_half_reg <= 1'b0;
            tick_cnt_reg   <= '0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            latch_half_reg <= latch_half_next;
            if (((state_next != state_reg) && (state_reg != ST_DONE)) || tick)
                tick_cnt_reg <= '0;
            else
                tick_cnt_reg <= tick_cnt_reg + TW'(1);
            if ((state_next == ST_LATCH) && (state_reg != ST_LATCH))
                frame_cnt_reg <= '0;
            else if (tick)
                frame_cnt_reg <= frame_cnt_reg + FW'(1);
        end
    end

    // Registered pin outputs and bit capture on each clock-low entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            snes_clk_reg   <= 1'b1;
            data_latch_reg <= 1'b0;
            data_valid_reg <= 1'b0;
            raw_reg        <= '0;
        end else begin
            snes_clk_reg   <= (state_next != ST_LOW);
            data_latch_reg <= (state_next == ST_LATCH);
            data_valid_reg <= (state_next == ST_DONE);
            if (enter_low)
                raw_reg <= {sync2_reg, raw_reg[15:1]};
        end
    end

`ifdef SNES_PRESENCE_CHECK_EN
    logic ctrl_missing_reg;

    // Publish the frame at DONE; a pad that leaves the trailing bits low is absent.
    always_ff @(posedge clk) begin
        if (reset) begin
            button_data_reg  <= '0;
            ctrl_missing_reg <= 1'b0;
        end else if (state_next == ST_DONE) begin
            if (raw_reg[15:12] != 4'b1111) begin
                button_data_reg  <= '0;
                ctrl_missing_reg <= 1'b1;
            end else begin
                button_data_reg  <= pressed;
                ctrl_missing_reg <= 1'b0;
            end
        end
    end

    assign ctrl_missing = ctrl_missing_reg;
`else
    // Publish the complete frame at DONE only, so the word never mixes frames.
    always_ff @(posedge clk) begin
        if (reset)
            button_data_reg <= '0;
        else if (state_next == ST_DONE)
            button_data_reg <= pressed;
    end

    assign ctrl_missing = 1'b0;
`endif

    assign snes_clk    = snes_clk_reg;
    assign data_latch  = data_latch_reg;
    assign data_valid  = data_valid_reg;
    assign button_data = button_data_reg;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader (HALF_PERIOD=4, POLL_TICKS=40).
module tb_snes_pad_reader;

    localparam int HP = 4;
    localparam int PT = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_data;
    logic        snes_clk;
    logic        data_latch;
    logic [11:0] button_data;
    logic        data_valid;
    logic        ctrl_missing;

    always #5 clk = ~clk;

    snes_pad_reader #(.HALF_PERIOD(HP), .POLL_TICKS(PT)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_data  (serial_data),
        .snes_clk     (snes_clk),
        .data_latch   (data_latch),
        .button_data  (button_data),
        .data_valid   (data_valid),
        .ctrl_missing (ctrl_missing)
    );

    typedef struct {
        logic [11:0] btn;
        logic        miss;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   rel = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc - rel);
    endtask

    // Pad model: latch loads the word, each rising pad clock advances one bit.
    logic [15:0] pad_word = 16'hFFFF;
    logic [15:0] pad_cur  = 16'hFFFF;
    int          pad_idx  = 16;

    always @(posedge data_latch or posedge snes_clk) begin
        if (data_latch) begin
            pad_idx = 0;
            pad_cur = pad_word;
        end else if (pad_idx < 16) begin
            pad_idx = pad_idx + 1;
        end
    end

    assign serial_data = (pad_idx < 16) ? pad_cur[pad_idx[3:0]] : 1'b1;

    // Monitor: pops an expectation on every data_valid, checks hold otherwise.
    logic [11:0] held = '0;
    always @(negedge clk) begin
        if (reset) begin
            held = '0;
        end else if (data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: data_valid at edge %0d, required no pulse", cyc - rel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("button_data", int'(button_data), int'(e.btn));
                check("ctrl_missing", int'(ctrl_missing), int'(e.miss));
                check("valid_edge", cyc - rel, e.edge_no);
                $display("frame: button_data=%03h ctrl_missing=%0b at edge %0d", button_data, ctrl_missing, cyc - rel);
                held = e.btn;
            end
        end else begin
            if (button_data != held) check("button_hold", int'(button_data), int'(held));
        end
    end

    logic lat [0:200];
    logic sck [0:200];

    initial begin
        int first_low, high_cnt, falls, bad_w, bad_s, last_fall, rise2, w;
        int k;

        repeat (4) @(negedge clk);
        check("rst_snes_clk", int'(snes_clk), 1);
        check("rst_data_latch", int'(data_latch), 0);
        check("rst_button_data", int'(button_data), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_ctrl_missing", int'(ctrl_missing), 0);

        // Frame 1: B, Start, Right, R pressed.
        pad_word = 16'hF776;
        exp_q.push_back('{12'h889, 1'b0, 141});
        rel   = cyc;
        reset = 1'b0;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            if (i <= 200) begin
                lat[i] = data_latch;
                sck[i] = snes_clk;
            end
            if (i == 150) begin
                // Frame 2: B, Select, Up, Right, R pressed.
                pad_word = 16'hF76A;
                exp_q.push_back('{12'h895, 1'b0, 301});
            end
        end
        lat[0] = 1'b0;
        sck[0] = 1'b1;

        high_cnt = 0;
        for (int i = 1; i <= 20; i++) if (lat[i]) high_cnt++;
        check("latch_width", high_cnt, 8);
        check("latch_first_edge", int'(lat[1]), 1);
        check("latch_end", int'(lat[9]), 0);

        first_low = -1;
        for (int i = 1; i <= 40; i++) if (!sck[i] && first_low < 0) first_low = i;
        check("first_low_edge", first_low, 13);

        falls = 0; bad_w = 0; bad_s = 0; last_fall = -1;
        for (int i = 1; i <= 160; i++) begin
            if (sck[i-1] && !sck[i]) begin
                falls++;
                if (last_fall >= 0 && i - last_fall != 8) bad_s++;
                last_fall = i;
                w = 0;
                for (int j = i; j <= 170 && !sck[j]; j++) w++;
                if (w != 4) bad_w++;
            end
        end
        check("low_pulse_count", falls, 16);
        check("low_width_errors", bad_w, 0);
        check("low_spacing_errors", bad_s, 0);

        rise2 = -1;
        for (int i = 2; i <= 170; i++) if (lat[i] && !lat[i-1] && rise2 < 0) rise2 = i;
        check("frame_period_edge", rise2, 161);

        // Mid-frame hold check, then frames 3 and 4.
        k = 170;
        while (k < 710) begin
            @(negedge clk);
            k++;
            if (k == 200) check("hold_889", int'(button_data), 12'h889);
            if (k == 310) begin
                pad_word = 16'h0000;
`ifdef SNES_PRESENCE_CHECK_EN
                exp_q.push_back('{12'h000, 1'b1, 461});
`else
                exp_q.push_back('{12'hFFF, 1'b0, 461});
`endif
            end
            if (k == 470) begin
                pad_word = 16'hFFFE;
                exp_q.push_back('{12'h001, 1'b0, 621});
            end
            if (k == 630) pad_word = 16'hF776;
        end

        // Frame 5 is in LOW(7); abort it with reset.
        check("low7_snes_clk", int'(snes_clk), 0);
        check("pre_abort_button", int'(button_data), 12'h001);
        reset = 1'b1;
        @(negedge clk);
        check("abort_snes_clk", int'(snes_clk), 1);
        check("abort_data_latch", int'(data_latch), 0);
        check("abort_button_data", int'(button_data), 0);
        check("abort_data_valid", int'(data_valid), 0);
        repeat (2) @(negedge clk);

        exp_q.push_back('{12'h889, 1'b0, 141});
        rel   = cyc;
        reset = 1'b0;
        @(negedge clk);
        check("restart_latch", int'(data_latch), 1);
        for (int i = 2; i <= 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check("final_ctrl_missing", int'(ctrl_missing), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
